// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard front-end: deserialises set-2 scan codes, tracks shift/caps,
// queues ASCII in a FIFO and presents the head with a level interrupt.
// Ports: clk50M/rst (async active-low), ps2_clk/ps2_data (async keyboard
// lines), kbd_int/kbd_data (pending flag and head char, 0x00 when empty),
// kbd_int_ack (rising edge pops), kbd_overflow (sticky dropped-char flag).
module ps2_kbd_ascii #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_int,
    output logic [7:0] kbd_data,
    input  logic       kbd_int_ack,
    output logic       kbd_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Returns {hit, ascii}; up selects uppercase letters, shf the digit row.
    function automatic logic [8:0] map_code(
        input logic [7:0] code,
        input logic       shf,
        input logic       up
    );
        logic [7:0] ch;
        logic       hit;
        logic       alpha;
        ch    = 8'h00;
        hit   = 1'b1;
        alpha = 1'b0;
        case (code)
            8'h1C: begin ch = "a"; alpha = 1'b1; end
            8'h32: begin ch = "b"; alpha = 1'b1; end
            8'h21: begin ch = "c"; alpha = 1'b1; end
            8'h23: begin ch = "d"; alpha = 1'b1; end
            8'h24: begin ch = "e"; alpha = 1'b1; end
            8'h2B: begin ch = "f"; alpha = 1'b1; end
            8'h34: begin ch = "g"; alpha = 1'b1; end
            8'h33: begin ch = "h"; alpha = 1'b1; end
            8'h43: begin ch = "i"; alpha = 1'b1; end
            8'h3B: begin ch = "j"; alpha = 1'b1; end
            8'h42: begin ch = "k"; alpha = 1'b1; end
            8'h4B: begin ch = "l"; alpha = 1'b1; end
            8'h3A: begin ch = "m"; alpha = 1'b1; end
            8'h31: begin ch = "n"; alpha = 1'b1; end
            8'h44: begin ch = "o"; alpha = 1'b1; end
            8'h4D: begin ch = "p"; alpha = 1'b1; end
            8'h15: begin ch = "q"; alpha = 1'b1; end
            8'h2D: begin ch = "r"; alpha = 1'b1; end
            8'h1B: begin ch = "s"; alpha = 1'b1; end
            8'h2C: begin ch = "t"; alpha = 1'b1; end
            8'h3C: begin ch = "u"; alpha = 1'b1; end
            8'h2A: begin ch = "v"; alpha = 1'b1; end
            8'h1D: begin ch = "w"; alpha = 1'b1; end
            8'h22: begin ch = "x"; alpha = 1'b1; end
            8'h35: begin ch = "y"; alpha = 1'b1; end
            8'h1A: begin ch = "z"; alpha = 1'b1; end
            8'h45: ch = shf ? ")" : "0";
            8'h16: ch = shf ? "!" : "1";
            8'h1E: ch = shf ? "@" : "2";
            8'h26: ch = shf ? "#" : "3";
            8'h25: ch = shf ? "$" : "4";
            8'h2E: ch = shf ? "%" : "5";
            8'h36: ch = shf ? "^" : "6";
            8'h3D: ch = shf ? "&" : "7";
            8'h3E: ch = shf ? "*" : "8";
            8'h46: ch = shf ? "(" : "9";
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            8'h0D: ch = 8'h09;
            8'h76: ch = 8'h1B;
            default: hit = 1'b0;
        endcase
        if (alpha && up) ch = ch - 8'h20;
        return {hit, ch};
    endfunction

    // Synchroniser and ps2_clk glitch filter
    logic [1:0] clk_sy;
    logic [1:0] dat_sy;
    logic [7:0] flt;
    logic       clk_f;
    logic       fall;

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            clk_sy <= 2'b11;
            dat_sy <= 2'b11;
            flt    <= 8'hFF;
            clk_f  <= 1'b1;
        end else begin
            clk_sy <= {clk_sy[0], ps2_clk};
            dat_sy <= {dat_sy[0], ps2_data};
            flt    <= {flt[6:0], clk_sy[1]};
            if (&flt)
                clk_f <= 1'b1;
            else if (~|flt)
                clk_f <= 1'b0;
        end
    end

    // Filtered level about to go 1->0 on this edge
    assign fall = clk_f & ~|flt;

    // Frame receiver
    rx_state_t       rx_st;
    logic [2:0]      bit_cnt;
    logic [7:0]      rx_sr;
    logic            rx_par;
    logic [TW-1:0]   tcnt;
    logic            byte_valid;
    logic [7:0]      rx_byte;

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            rx_st      <= RX_IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            rx_par     <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (rx_st)
                    RX_IDLE: begin
                        if (!dat_sy[1]) begin
                            rx_st   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        rx_sr   <= {dat_sy[1], rx_sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            rx_st <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        rx_par <= dat_sy[1];
                        rx_st  <= RX_STOP;
                    end
                    default: begin
                        if (dat_sy[1] && (^{rx_sr, rx_par})) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_sr;
                        end
                        rx_st <= RX_IDLE;
                    end
                endcase
            end else if (rx_st != RX_IDLE) begin
                if (tcnt == TMAX) begin
                    rx_st <= RX_IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    // Scan-code decoder
    logic       brk;
    logic       ext;
    logic       shift_q;
    logic       caps;
    logic       dec_valid;
    logic [7:0] dec_char;
    logic [8:0] map;

    assign map = map_code(rx_byte, shift_q, shift_q ^ caps);

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            brk       <= 1'b0;
            ext       <= 1'b0;
            shift_q   <= 1'b0;
            caps      <= 1'b0;
            dec_valid <= 1'b0;
            dec_char  <= '0;
        end else begin
            dec_valid <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!ext) begin
                        if (rx_byte == 8'h12 || rx_byte == 8'h59) begin
                            shift_q <= !brk;
                        end else if (rx_byte == 8'h58) begin
                            if (!brk) caps <= !caps;
                        end else if (!brk && map[8]) begin
                            dec_valid <= 1'b1;
                            dec_char  <= map[7:0];
                        end
                    end
                end
            end
        end
    end

    // Character FIFO and acknowledge handling
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW-1:0] rp_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] left;
    logic          ack_d;
    logic          full;
    logic          wr;
    logic          pop;
    logic [7:0]    head_nx;

    assign full = (cnt == FULL);
    assign wr   = dec_valid & ~full;
    assign pop  = kbd_int_ack & ~ack_d & (cnt != '0);
    assign left = cnt - CW'(pop);

    // Outputs are registered from next-state so they track the FIFO
    // on the same edge that writes or pops it.
    always_comb begin
        cnt_nx  = cnt;
        rp_nx   = pop ? rp + 1'b1 : rp;
        head_nx = 8'h00;
        if (wr && !pop)
            cnt_nx = cnt + 1'b1;
        else if (pop && !wr)
            cnt_nx = cnt - 1'b1;
        if (cnt_nx != '0) begin
            if (wr && left == '0)
                head_nx = dec_char;
            else
                head_nx = mem[rp_nx];
        end
    end

    always_ff @(posedge clk50M) begin
        if (wr) mem[wp] <= dec_char;
    end

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            wp           <= '0;
            rp           <= '0;
            cnt          <= '0;
            ack_d        <= 1'b0;
            kbd_int      <= 1'b0;
            kbd_data     <= 8'h00;
            kbd_overflow <= 1'b0;
        end else begin
            ack_d    <= kbd_int_ack;
            rp       <= rp_nx;
            cnt      <= cnt_nx;
            kbd_int  <= (cnt_nx != '0);
            kbd_data <= head_nx;
            if (wr) wp <= wp + 1'b1;
            if (dec_valid && full) kbd_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed testbench for ps2_kbd_ascii: drives PS/2 frames and checks
// the ASCII FIFO, interrupt, acknowledge and overflow behaviour.
module tb_ps2_kbd_ascii;

    localparam int DEPTH = 4;
    localparam int TO    = 400;
    localparam int H     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ack;
    logic       kbd_int;
    logic [7:0] kbd_data;
    logic       ovf;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   lat = 0;
    event ev_stop;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_kbd_ascii #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk50M      (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd_int     (kbd_int),
        .kbd_data    (kbd_data),
        .kbd_int_ack (ack),
        .kbd_overflow(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] code, input logic bad);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            cycles(H);
            ps2_clk = 1'b0;
            if (i == 10) begin
                fall_cyc = cyc;
                -> ev_stop;
            end
            cycles(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cycles(H);
    endtask

    task automatic send(input logic [7:0] code);
        frame(code, 1'b0);
    endtask

    task automatic partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            cycles(H);
            ps2_clk = 1'b0;
            cycles(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic wait_int();
        int k;
        k = 0;
        while (!kbd_int && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        wait_int();
        check({tag, " int"}, kbd_int, 1);
        check({tag, " data"}, kbd_data, exp);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic empty(input string tag);
        check(tag, {kbd_int, kbd_data}, 9'h000);
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ack      = 1'b0;
        cycles(3);
        check("rst int", kbd_int, 0);
        check("rst data", kbd_data, 8'h00);
        check("rst ovf", ovf, 0);
        rst = 1'b1;
        cycles(5);

        // Single key and acknowledge
        send(8'h1C);
        check("1C int", kbd_int, 1);
        check("1C data", kbd_data, 8'h61);
        ack = 1'b1;
        @(negedge clk);
        empty("1C popped");
        ack = 1'b0;
        cycles(2);

        // Shift, break codes, caps lock
        send(8'h12);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        send(8'h1C);
        pop("shift A", 8'h41);
        pop("plain a", 8'h61);
        empty("shift empty");
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        send(8'h16);
        pop("caps 1", 8'h31);
        send(8'h1C);
        pop("caps A", 8'h41);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        empty("caps off");

        // Bad parity, then timeout of a partial frame
        frame(8'h1C, 1'b1);
        cycles(5);
        empty("bad parity");
        partial(4);
        cycles(TO + 100);
        empty("partial");
        send(8'h2D);
        pop("after to", 8'h72);
        empty("to only one");

        // Overflow
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        send(8'h24);
        send(8'h2B);
        check("ovf set", ovf, 1);
        pop("ovf a", 8'h61);
        pop("ovf b", 8'h62);
        pop("ovf c", 8'h63);
        pop("ovf d", 8'h64);
        empty("ovf drained");
        check("ovf sticky", ovf, 1);

        // Held acknowledge pops once
        send(8'h1C);
        send(8'h32);
        @(negedge clk);
        ack = 1'b1;
        cycles(6);
        check("held int", kbd_int, 1);
        check("held data", kbd_data, 8'h62);
        ack = 1'b0;
        cycles(2);
        pop("held b", 8'h62);
        empty("held empty");

        // Write-to-interrupt latency, measured on an empty FIFO
        fork
            send(8'h29);
            begin
                int k;
                @(ev_stop);
                k = 0;
                while (!kbd_int && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                lat = cyc - fall_cyc;
            end
        join
        pop("cal", 8'h20);

        // Pop lands on the same edge as a write into a non-empty FIFO
        send(8'h1C);
        fork
            send(8'h32);
            begin
                int k;
                @(ev_stop);
                k = 0;
                while (cyc < fall_cyc + lat - 1 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        check("same int", kbd_int, 1);
        check("same data", kbd_data, 8'h62);
        pop("same b", 8'h62);
        empty("same count");

        // Reset mid-frame with queued characters
        send(8'h1C);
        send(8'h32);
        partial(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst int", kbd_int, 0);
        check("mid rst data", kbd_data, 8'h00);
        check("mid rst ovf", ovf, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cycles(3);
        rst = 1'b1;
        cycles(5);
        empty("post rst");
        send(8'h29);
        pop("post rst sp", 8'h20);
        empty("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
